// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if
// Groups the scan controller's datapath-side inputs and display-side outputs.
//   en         : scan enable; 0 forces the display dark
//   load       : one-cycle strobe capturing digits_in
//   digits_in  : packed BCD, bits [4k+3:4k] are digit k
//   bcd_out    : code to the shared 7-segment decoder (4'hF = blank)
//   dig_en_n   : active-low digit enables, at most one low at a time
//   frame_done : one-cycle pulse at the end of each scan frame
// master: the logic feeding digits in; slave: the scan controller.
interface display_scan_ctrl_if #(
  parameter int unsigned N_DIGITS = 4
) ();
  logic                    en;
  logic                    load;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic [3:0]              bcd_out;
  logic [N_DIGITS-1:0]     dig_en_n;
  logic                    frame_done;

  modport master (
    output en, load, digits_in,
    input  bcd_out, dig_en_n, frame_done
  );

  modport slave (
    input  en, load, digits_in,
    output bcd_out, dig_en_n, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexed scan controller sharing one BCD-to-7-segment decoder across
// N_DIGITS common-anode digits. A pending buffer captures loads at any time;
// the displayed shadow buffer only changes at frame boundaries so digits never
// tear. Each digit is lit for SHOW_CYCLES, separated by BLANK_CYCLES of dark.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : display_scan_ctrl_if.slave (en, load, digits_in -> bcd_out,
//           dig_en_n, frame_done); all outputs registered
// Optional: define SCAN_LZ_BLANK_EN to compile in leading-zero suppression
// (digit k>0 is blanked when it and every more significant digit are zero).
module display_scan_ctrl #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SHOW_CYCLES  = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_ctrl_if.slave   bus
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned IDX_W      = $clog2(N_DIGITS);
  localparam int unsigned DW         = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]       pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  logic [DW-1:0]       shadow_q, shadow_d;
  logic [3:0]          bcd_out_q, bcd_out_d;
  logic [N_DIGITS-1:0] dig_en_n_q, dig_en_n_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_wrap;

  // State and buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= '1;
      pend_v_q     <= 1'b0;
      shadow_q     <= '1;
      bcd_out_q    <= 4'hF;
      dig_en_n_q   <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      shadow_q     <= shadow_d;
      bcd_out_q    <= bcd_out_d;
      dig_en_n_q   <= dig_en_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: counter, digit index and frame-wrap detection
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CNT_W'(1);
    frame_wrap = 1'b0;
    if (!bus.en) begin
      state_d = ST_BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d      = '0;
              frame_wrap = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Double buffer. While disabled every cycle counts as a frame boundary, so
  // pending is already in shadow by the time scanning resumes. A load that
  // coincides with a boundary bypasses pending and lands in shadow directly.
  always_comb begin
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    shadow_d  = shadow_q;
    if (bus.load) begin
      pending_d = bus.digits_in;
      pend_v_d  = 1'b1;
    end
    if (frame_wrap || !bus.en) begin
      if (bus.load) begin
        shadow_d = bus.digits_in;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        shadow_d = pending_q;
        pend_v_d = 1'b0;
      end
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe.
  always_comb begin : out_comb
    logic [3:0] digit;
`ifdef SCAN_LZ_BLANK_EN
    logic       zero_run;
    zero_run = 1'b1;
`endif
    digit        = 4'hF;
    dig_en_n_d   = '1;
    bcd_out_d    = 4'hF;
    frame_done_d = frame_wrap;
    // Walk from the most significant digit down so zero_run reflects all
    // digits at and above the one being selected.
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
`ifdef SCAN_LZ_BLANK_EN
      zero_run = zero_run & (shadow_d[4*(N_DIGITS-1-j) +: 4] == 4'h0);
`endif
      if (idx_d == IDX_W'(N_DIGITS - 1 - j)) begin
        digit = shadow_d[4*(N_DIGITS-1-j) +: 4];
`ifdef SCAN_LZ_BLANK_EN
        if (zero_run && (j != N_DIGITS - 1)) begin
          digit = 4'hF;
        end
`endif
      end
    end
    if (state_d == ST_SHOW) begin
      bcd_out_d = digit;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        if (idx_d == IDX_W'(k)) begin
          dig_en_n_d[k] = 1'b0;
        end
      end
    end
  end

  assign bus.bcd_out    = bcd_out_q;
  assign bus.dig_en_n   = dig_en_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller that shares a single `bcd2seven_segment` decoder among N common-anode digits. It double-buffers a packed BCD word, steps through the digits with a configurable on-time, and inserts a blanking gap between digits to suppress ghosting. It drives the decoder's 4-bit `in` port and the active-low digit enables, and sits between the counting/datapath logic and the board's display pins.

## Interface
- `N_DIGITS`, 4: number of digits scanned; legal range 2..8; digit N_DIGITS-1 is the most significant.
- `SHOW_CYCLES`, 1000: clock cycles each digit is lit; must be ≥1.
- `BLANK_CYCLES`, 16: clock cycles all digits are dark between two lit digits; must be ≥1.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  scan enable; 0 forces the display dark.
- `load`  in  1  one-cycle strobe that captures `digits_in`.
- `digits_in`  in  4*N_DIGITS  packed BCD; bits [4k+3:4k] are digit k.
- `bcd_out`  out  4  code to the decoder `in` port; 4'hF means blank, because the decoder turns every segment off for codes 10–15.
- `dig_en_n`  out  N_DIGITS  active-low digit enables; at most one bit is low at a time.
- `frame_done`  out  1  one-cycle pulse at the end of each full scan frame.

## Operation
- The block has two registers:
  - pending (4*N_DIGITS bits) plus a `pend_v` flag;
  - shadow (4*N_DIGITS bits), which is what gets displayed.
- `load`=1 writes `digits_in` into pending and sets `pend_v`.
- FSM state BLANK: `dig_en_n` is all 1, `bcd_out`=4'hF, and the counter runs for BLANK_CYCLES. It then goes to SHOW with the current index.
- FSM state SHOW: `dig_en_n[idx]`=0, `bcd_out`=shadow digit idx, and the counter runs for SHOW_CYCLES. It then goes to BLANK with idx advanced.
- Index advance: idx←idx+1, wrapping from N_DIGITS-1 to 0.
- Frame boundary: the SHOW→BLANK edge where idx wraps to 0.
  - `frame_done`=1 for exactly that cycle.
  - If `pend_v` is set, shadow←pending and `pend_v` is cleared.
- Frame-boundary load conflict: if `load` is high on the frame-boundary cycle, shadow←`digits_in` directly and `pend_v` ends cleared.
- Shadow never changes mid-frame, so no digit tears.
- `en`=0, from any state: on the next edge go to BLANK with idx=0 and counter=0, then hold there. `frame_done` stays 0. `load` still works.
- `en` 0→1: a full BLANK period, then digit 0. The return to scanning is treated as a frame boundary, so pending is transferred.
- Codes 10–15 in shadow pass through unchanged; the decoder renders them blank.

## Timing
- All outputs are registered.
- Reset values:
  - state BLANK, idx 0, counter 0;
  - `dig_en_n` all 1, `bcd_out` 4'hF, `frame_done` 0;
  - shadow all 4'hF, pending all 4'hF, `pend_v` 0.
- Reset asserted mid-frame takes effect at the next edge with the values above.
- First edge after `rst_n` rises (`en`=1): the output is dark for exactly BLANK_CYCLES cycles, then digit 0 is lit.
- Each digit is low on `dig_en_n` for exactly SHOW_CYCLES consecutive cycles. The dark gap between digits is exactly BLANK_CYCLES cycles.
- Frame period is N_DIGITS*(SHOW_CYCLES+BLANK_CYCLES).
- Load-to-display latency is at most one frame plus BLANK_CYCLES.
- Counter width is clog2(max(SHOW_CYCLES, BLANK_CYCLES)). The counter resets to 0 on every state change and never wraps inside a state.

## Configuration
- `SCAN_LZ_BLANK_EN` defined: leading-zero suppression is compiled in.
  - While showing digit k, if every shadow digit from N_DIGITS-1 down to k is 4'h0 and k>0, `bcd_out`=4'hF.
  - Digit 0 is always shown.
  - `dig_en_n` timing is unchanged.
- `SCAN_LZ_BLANK_EN` undefined: zeros are displayed as-is and no suppression logic is built.

## Test plan
All scenarios use N_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=2.
- Reset, then `en`=1 with no load: `bcd_out` is 4'hF throughout. `dig_en_n` sequence is 1111×2, 1110×4, 1111×2, 1101×4, … `frame_done` pulses every 24 cycles.
- `load` with `digits_in`=16'h1234 mid-frame: the current frame still shows F. The next frame shows `bcd_out` 4,3,2,1 on digits 0..3.
- `load` on the frame-boundary cycle with 16'h5678: the very next frame shows 8,7,6,5 and `pend_v` is 0.
- Drop `en` during SHOW of digit 2: the next cycle is all dark. Re-raise `en`: 2 dark cycles, then digit 0 lit.
- `rst_n`=0 for 1 cycle mid-SHOW: the next edge gives `dig_en_n`=4'hF, `bcd_out`=4'hF, and shadow reads back as 16'hFFFF.
- With `SCAN_LZ_BLANK_EN` and shadow=16'h0070: digits 3 and 2 show 4'hF, digit 1 shows 7, digit 0 shows 0. With shadow=16'h0000, only digit 0 shows 0.
